// File: rtl/alu_rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_rf_sequencer
// Purpose  : Multi-cycle issue/execute/writeback sequencer placed in front of
//            a register file (2 combinational read ports, 1 write port) and
//            a 2-bit-opcode ALU. Accepts one instruction per valid/ready
//            handshake, reads two sources, runs the ALU and writes the result
//            back. Immediate loads skip the read/execute steps.
// Ports    : CLK, RST (sync, active high)
//            instr_valid/instr_ready handshake, instr_load/op/rs1/rs2/rd/imm
//            rf_A1/rf_A2 read addresses, rf_RD1/rf_RD2 read data
//            rf_A3/rf_WD3/rf_WE3 write port
//            alu_A/alu_B/alu_opcode to the ALU, alu_result back
//            done (1-cycle pulse), done_value, busy, retired counter
// Revision : 1.0 - initial release
// ============================================================================
module alu_rf_sequencer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              instr_load,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_A1,
  output logic [ADDR_W-1:0] rf_A2,
  output logic [ADDR_W-1:0] rf_A3,
  output logic [DATA_W-1:0] rf_WD3,
  output logic              rf_WE3,
  input  logic [DATA_W-1:0] rf_RD1,
  input  logic [DATA_W-1:0] rf_RD2,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic [DATA_W-1:0] done_value,
  output logic              busy,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              w_accept;

  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_rs1;
  logic [ADDR_W-1:0] r_rs2;
  logic [ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_res;

  logic              r_done;
  logic [DATA_W-1:0] r_done_value;
  logic [CNT_W-1:0]  r_retired;

  assign w_accept = instr_valid && (r_state == S_IDLE);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          // Immediate loads already have their result at accept time.
          w_next = instr_load ? S_WB : S_READ;
        end
      end
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WB;
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: every bus is zero outside the state that owns it
  // --------------------------------------------------------------------------
  always_comb begin
    instr_ready = 1'b0;
    rf_A1       = '0;
    rf_A2       = '0;
    alu_A       = '0;
    alu_B       = '0;
    alu_opcode  = 2'b00;
    rf_A3       = '0;
    rf_WD3      = '0;
    rf_WE3      = 1'b0;
    case (r_state)
      S_IDLE: instr_ready = 1'b1;
      S_READ: begin
        rf_A1 = r_rs1;
        rf_A2 = r_rs2;
      end
      S_EXEC: begin
        alu_A      = r_opa;
        alu_B      = r_opb;
        alu_opcode = r_op;
      end
      S_WB: begin
        rf_A3  = r_rd;
        rf_WD3 = r_res;
        // A reset landing on the writeback cycle must not corrupt the RF.
        rf_WE3 = ~RST;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction latches and operand/result pipeline registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_op  <= 2'b00;
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_rd  <= '0;
      r_opa <= '0;
      r_opb <= '0;
      r_res <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= instr_op;
        r_rs1 <= instr_rs1;
        r_rs2 <= instr_rs2;
        r_rd  <= instr_rd;
        if (instr_load) begin
          r_res <= instr_imm;
        end
      end
      if (r_state == S_READ) begin
        r_opa <= rf_RD1;
        r_opb <= rf_RD2;
      end
      if (r_state == S_EXEC) begin
        r_res <= alu_result;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Completion reporting
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_done       <= 1'b0;
      r_done_value <= '0;
      r_retired    <= '0;
    end else if (r_state == S_WB) begin
      r_done       <= 1'b1;
      r_done_value <= r_res;
      r_retired    <= r_retired + CNT_W'(1);  // wraps silently
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done       = r_done;
  assign done_value = r_done_value;
  assign retired    = r_retired;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_rf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rf_sequencer
// Purpose  : Self-checking bench for alu_rf_sequencer. Supplies a register
//            file and ALU around the sequencer and compares every writeback
//            against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rf_sequencer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 2;   // small so the retired counter wraps quickly

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic              instr_load = 1'b0;
  logic [1:0]        instr_op = 2'b00;
  logic [ADDR_W-1:0] instr_rs1 = '0;
  logic [ADDR_W-1:0] instr_rs2 = '0;
  logic [ADDR_W-1:0] instr_rd = '0;
  logic [DATA_W-1:0] instr_imm = '0;
  logic [ADDR_W-1:0] rf_A1, rf_A2, rf_A3;
  logic [DATA_W-1:0] rf_WD3, rf_RD1, rf_RD2;
  logic              rf_WE3;
  logic [DATA_W-1:0] alu_A, alu_B, alu_result;
  logic [1:0]        alu_opcode;
  logic              done, busy;
  logic [DATA_W-1:0] done_value;
  logic [CNT_W-1:0]  retired;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  alu_rf_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .CLK(CLK), .RST(RST),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_load(instr_load), .instr_op(instr_op),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .instr_imm(instr_imm),
    .rf_A1(rf_A1), .rf_A2(rf_A2), .rf_A3(rf_A3), .rf_WD3(rf_WD3),
    .rf_WE3(rf_WE3), .rf_RD1(rf_RD1), .rf_RD2(rf_RD2),
    .alu_A(alu_A), .alu_B(alu_B), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .done(done), .done_value(done_value), .busy(busy), .retired(retired)
  );

  // ---------------- environment: register file and ALU ----------------
  logic [DATA_W-1:0] env_rf [32];
  logic              env_clear = 1'b1;

  assign rf_RD1 = env_rf[rf_A1];
  assign rf_RD2 = env_rf[rf_A2];

  always @(posedge CLK) begin
    if (env_clear) begin
      for (int i = 0; i < 32; i++) env_rf[i] <= '0;
    end else if (rf_WE3) begin
      env_rf[rf_A3] <= rf_WD3;
    end
  end

  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      2'd0: alu_result = alu_A + alu_B;
      2'd1: alu_result = alu_A - alu_B;
      2'd2: alu_result = alu_A << alu_B;
      2'd3: alu_result = alu_A >> alu_B;
      default: alu_result = '0;
    endcase
  end

  // ---------------- instruction-level reference model ----------------
  logic [DATA_W-1:0] m_rf [32];
  int                m_ret = 0;

  function automatic logic [DATA_W-1:0] ref_exec(input bit ld, input logic [1:0] op,
      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] imm);
    longint unsigned wa, wb, m;
    wa = a; wb = b; m = 64'd1 << DATA_W;
    if (ld) return imm;
    case (op)
      2'd0: return DATA_W'((wa + wb) % m);
      2'd1: return DATA_W'((wa + m - wb) % m);
      2'd2: return (wb >= DATA_W) ? '0 : DATA_W'((wa * (64'd1 << wb)) % m);
      default: return (wb >= DATA_W) ? '0 : DATA_W'(wa / (64'd1 << wb));
    endcase
  endfunction

  typedef struct {
    bit                ld;
    logic [1:0]        op;
    logic [ADDR_W-1:0] s1, s2, d;
    logic [DATA_W-1:0] imm, exp;
  } dir_t;

  dir_t dir_tbl [11] = '{
    '{1'b1, 2'd0, 5'd0, 5'd0, 5'd1, 32'd7, 32'd7},
    '{1'b1, 2'd0, 5'd0, 5'd0, 5'd2, 32'd5, 32'd5},
    '{1'b0, 2'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'd12},
    '{1'b1, 2'd0, 5'd0, 5'd0, 5'd1, 32'd5, 32'd5},
    '{1'b1, 2'd0, 5'd0, 5'd0, 5'd2, 32'd7, 32'd7},
    '{1'b0, 2'd1, 5'd1, 5'd2, 5'd4, 32'd0, 32'hFFFF_FFFE},
    '{1'b0, 2'd2, 5'd1, 5'd2, 5'd5, 32'd0, 32'h0000_0280},
    '{1'b0, 2'd3, 5'd1, 5'd2, 5'd6, 32'd0, 32'd0},
    '{1'b1, 2'd0, 5'd0, 5'd0, 5'd1, 32'd7, 32'd7},
    '{1'b0, 2'd0, 5'd1, 5'd1, 5'd1, 32'd0, 32'd14},
    '{1'b0, 2'd0, 5'd1, 5'd1, 5'd2, 32'd0, 32'd28}
  };

  // Drives one instruction (caller is at a falling edge) and observes its
  // writeback and completion. Latencies count rising edges after the accept.
  task automatic run_instr(input bit ld, input logic [1:0] op,
      input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2,
      input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] imm,
      input bit hold_valid, input bit scramble,
      output int acc_cyc, output int wr_lat, output logic [ADDR_W-1:0] wr_a,
      output logic [DATA_W-1:0] wr_d, output int done_lat,
      output logic [DATA_W-1:0] dval, output logic [CNT_W-1:0] ret);
    int waitc;
    instr_load = ld; instr_op = op; instr_rs1 = s1; instr_rs2 = s2;
    instr_rd = d; instr_imm = imm; instr_valid = 1'b1;
    acc_cyc = -1; wr_lat = -1; done_lat = -1;
    wr_a = '0; wr_d = '0; dval = '0; ret = '0;
    waitc = 0;
    while (!instr_ready && waitc < 20) begin
      @(negedge CLK);
      waitc++;
    end
    if (!instr_ready) begin
      instr_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    acc_cyc = int'($time / 10);
    #1;
    if (!hold_valid) instr_valid = 1'b0;
    for (int c = 0; c < 8 && done_lat < 0; c++) begin
      @(negedge CLK);
      if (rf_WE3 && wr_lat < 0) begin
        wr_lat = c + 1; wr_a = rf_A3; wr_d = rf_WD3;
      end
      if (done) begin
        done_lat = c; dval = done_value; ret = retired;
      end else if (scramble && !instr_ready) begin
        instr_load = 1'($urandom); instr_op = 2'($urandom);
        instr_rs1 = 5'($urandom); instr_rs2 = 5'($urandom);
        instr_rd = 5'($urandom); instr_imm = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; env_clear = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (retired !== '0) begin failures++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    checks++; if (done_value !== '0) begin failures++; $display("FAIL reset_done_value: got %h expected 0", done_value); end
    checks++; if (rf_WE3 !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", rf_WE3); end
    checks++; if ({rf_A1, rf_A2, rf_A3, alu_A, alu_B, alu_opcode} !== '0) begin
      failures++; $display("FAIL reset_buses: got nonzero expected all zero");
    end
    RST = 1'b0; env_clear = 1'b0;
    m_ret = 0;
  endtask

  task automatic test_directed();
    int acc, wl, dl, lat;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd, dv, mexp;
    logic [CNT_W-1:0] rt;
    for (int i = 0; i < 11; i++) begin
      mexp = ref_exec(dir_tbl[i].ld, dir_tbl[i].op, m_rf[dir_tbl[i].s1], m_rf[dir_tbl[i].s2], dir_tbl[i].imm);
      m_rf[dir_tbl[i].d] = mexp; m_ret++;
      lat = dir_tbl[i].ld ? 1 : 3;
      run_instr(dir_tbl[i].ld, dir_tbl[i].op, dir_tbl[i].s1, dir_tbl[i].s2, dir_tbl[i].d,
                dir_tbl[i].imm, 1'b0, 1'b0, acc, wl, wa, wd, dl, dv, rt);
      checks++; if (acc < 0 || dl < 0) begin failures++; $display("FAIL dir_timeout[%0d]: got acc=%0d done=%0d expected both >=0", i, acc, dl); end
      checks++; if (wd !== dir_tbl[i].exp) begin failures++; $display("FAIL dir_wdata[%0d]: got %h expected %h", i, wd, dir_tbl[i].exp); end
      checks++; if (wa !== dir_tbl[i].d) begin failures++; $display("FAIL dir_waddr[%0d]: got %0d expected %0d", i, wa, dir_tbl[i].d); end
      checks++; if (wl != lat) begin failures++; $display("FAIL dir_wlat[%0d]: got %0d expected %0d", i, wl, lat); end
      checks++; if (dl != lat) begin failures++; $display("FAIL dir_donelat[%0d]: got %0d expected %0d", i, dl, lat); end
      checks++; if (dv !== dir_tbl[i].exp) begin failures++; $display("FAIL dir_done_value[%0d]: got %h expected %h", i, dv, dir_tbl[i].exp); end
      checks++; if (rt !== CNT_W'(m_ret)) begin failures++; $display("FAIL dir_retired[%0d]: got %0d expected %0d", i, rt, CNT_W'(m_ret)); end
    end
    @(negedge CLK);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL dir_done_pulse: got %b expected 0", done); end
    checks++; if (env_rf[3] !== 32'd12) begin failures++; $display("FAIL dir_rf_r3: got %h expected 0000000c", env_rf[3]); end
  endtask

  task automatic test_random();
    int acc, wl, dl, lat;
    bit ld;
    logic [1:0] op;
    logic [ADDR_W-1:0] s1, s2, d, wa;
    logic [DATA_W-1:0] imm, exp, wd, dv;
    logic [CNT_W-1:0] rt;
    for (int i = 0; i < 40; i++) begin
      ld = ($urandom_range(0, 9) < 3);
      op = 2'($urandom);
      s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
      imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      exp = ref_exec(ld, op, m_rf[s1], m_rf[s2], imm);
      m_rf[d] = exp; m_ret++;
      lat = ld ? 1 : 3;
      run_instr(ld, op, s1, s2, d, imm, 1'b0, 1'b0, acc, wl, wa, wd, dl, dv, rt);
      checks++; if (acc < 0 || dl < 0) begin failures++; $display("FAIL rand_timeout[%0d]: got acc=%0d done=%0d expected both >=0", i, acc, dl); end
      checks++; if (wd !== exp) begin failures++; $display("FAIL rand_wdata[%0d]: got %h expected %h", i, wd, exp); end
      checks++; if (wa !== d) begin failures++; $display("FAIL rand_waddr[%0d]: got %0d expected %0d", i, wa, d); end
      checks++; if (wl != lat || dl != lat) begin failures++; $display("FAIL rand_latency[%0d]: got wr=%0d done=%0d expected %0d", i, wl, dl, lat); end
      checks++; if (dv !== exp) begin failures++; $display("FAIL rand_done_value[%0d]: got %h expected %h", i, dv, exp); end
      checks++; if (rt !== CNT_W'(m_ret)) begin failures++; $display("FAIL rand_retired[%0d]: got %0d expected %0d", i, rt, CNT_W'(m_ret)); end
    end
  endtask

  // instr_valid stays high throughout; fields are scrambled while not ready.
  task automatic test_back_to_back();
    int acc, prev_acc, wl, dl;
    bit ld, prev_ld;
    logic [1:0] op;
    logic [ADDR_W-1:0] s1, s2, d, wa;
    logic [DATA_W-1:0] imm, exp, wd, dv;
    logic [CNT_W-1:0] rt;
    prev_acc = 0; prev_ld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld = (i >= 5);
      op = 2'($urandom);
      s1 = 5'($urandom_range(0, 7)); s2 = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
      imm = $urandom;
      exp = ref_exec(ld, op, m_rf[s1], m_rf[s2], imm);
      m_rf[d] = exp; m_ret++;
      run_instr(ld, op, s1, s2, d, imm, 1'b1, 1'b1, acc, wl, wa, wd, dl, dv, rt);
      checks++; if (wd !== exp || wa !== d) begin failures++; $display("FAIL b2b_write[%0d]: got r%0d=%h expected r%0d=%h", i, wa, wd, d, exp); end
      if (i > 0) begin
        checks++; if (acc - prev_acc != (prev_ld ? 2 : 4)) begin
          failures++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", i, acc - prev_acc, prev_ld ? 2 : 4);
        end
      end
      prev_acc = acc; prev_ld = ld;
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_reset_midop();
    int acc, wl, dl, waitc;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd, dv, old7;
    logic [CNT_W-1:0] rt;
    run_instr(1'b1, 2'd0, 5'd0, 5'd0, 5'd1, 32'd3, 1'b0, 1'b0, acc, wl, wa, wd, dl, dv, rt);
    run_instr(1'b1, 2'd0, 5'd0, 5'd0, 5'd2, 32'd4, 1'b0, 1'b0, acc, wl, wa, wd, dl, dv, rt);
    run_instr(1'b1, 2'd0, 5'd0, 5'd0, 5'd7, 32'd99, 1'b0, 1'b0, acc, wl, wa, wd, dl, dv, rt);
    m_rf[1] = 32'd3; m_rf[2] = 32'd4; m_rf[7] = 32'd99;
    instr_load = 1'b0; instr_op = 2'd0; instr_rs1 = 5'd1; instr_rs2 = 5'd2; instr_rd = 5'd7;
    instr_valid = 1'b1;
    waitc = 0;
    while (!instr_ready && waitc < 20) begin @(negedge CLK); waitc++; end
    @(posedge CLK); #1; instr_valid = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (rf_WE3 !== 1'b1) begin failures++; $display("FAIL midop_in_wb: got we=%b expected 1", rf_WE3); end
    old7 = env_rf[7];
    RST = 1'b1;
    #1;
    checks++; if (rf_WE3 !== 1'b0) begin failures++; $display("FAIL midop_we_gated: got %b expected 0", rf_WE3); end
    @(negedge CLK);
    checks++; if (env_rf[7] !== 32'd99) begin failures++; $display("FAIL midop_r7: got %h expected %h", env_rf[7], old7); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midop_done: got %b expected 0", done); end
    checks++; if (retired !== '0) begin failures++; $display("FAIL midop_retired: got %0d expected 0", retired); end
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL midop_ready: got %b expected 1", instr_ready); end
    RST = 1'b0;
    m_ret = 0;
  endtask

  task automatic test_counter_wrap();
    int acc, wl, dl;
    int exp_seq [5];
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd, dv, imm;
    logic [CNT_W-1:0] rt;
    exp_seq = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      imm = $urandom;
      m_rf[8 + i] = imm; m_ret++;
      run_instr(1'b1, 2'd0, 5'd0, 5'd0, 5'(8 + i), imm, 1'b0, 1'b0, acc, wl, wa, wd, dl, dv, rt);
      checks++; if (dl < 0 || rt !== CNT_W'(exp_seq[i])) begin
        failures++; $display("FAIL wrap_retired[%0d]: got %0d expected %0d", i, rt, exp_seq[i]);
      end
      checks++; if (dv !== imm) begin failures++; $display("FAIL wrap_done_value[%0d]: got %h expected %h", i, dv, imm); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_counter_wrap();
    for (int i = 0; i < 32; i++) begin
      checks++; if (env_rf[i] !== m_rf[i]) begin failures++; $display("FAIL final_rf[%0d]: got %h expected %h", i, env_rf[i], m_rf[i]); end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
